// File: rtl/pid_sched_pkg.sv
// pid_sched_pkg: shared types, result width and mask search helper for the PID update scheduler.
package pid_sched_pkg;
  localparam int RESULT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_STROBE,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } next_bit_t;

  // Lowest set bit of mask at or above position from; from = 8 never matches.
  function automatic next_bit_t next_set_bit(input logic [7:0] mask, input logic [3:0] from);
    next_bit_t r;
    r = '0;
    for (int i = 7; i >= 0; i--)
      if (mask[i] && i >= int'(from)) r = '{found: 1'b1, idx: 3'(i)};
    return r;
  endfunction
endpackage

// File: rtl/control_tick_gen.sv
// control_tick_gen: prescaler producing a one-cycle control tick every TICK_DIV clocks while enabled.
module control_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic i_enable,
  output logic o_tick
);
  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last = r_count == CW'(TICK_DIV - 1);
  assign o_tick = i_enable && w_last;

  always_ff @(posedge clock or posedge reset)
    if (reset) r_count <= '0;
    else       r_count <= (!i_enable || w_last) ? '0 : r_count + CW'(1);
endmodule

// File: rtl/pid_update_scheduler.sv
// pid_update_scheduler: sweeps one shared PID datapath across the enabled motors on every control tick
// and latches each motor's result into its own output slot.
module pid_update_scheduler
  import pid_sched_pkg::*;
#(
  parameter int NUM_MOTORS    = 6,
  parameter int IDX_W         = 3,
  parameter int TICK_DIV      = 50000,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           i_enable,
  input  logic [NUM_MOTORS-1:0]          i_motor_enable_mask,
  input  logic signed [RESULT_W-1:0]     i_pid_result,
  input  logic                           i_overrun_clear,
  output logic [IDX_W-1:0]               o_motor_sel,
  output logic                           o_pid_update,
  output logic [RESULT_W*NUM_MOTORS-1:0] o_result_flat,
  output logic [NUM_MOTORS-1:0]          o_result_valid,
  output logic                           o_sweep_busy,
  output logic                           o_sweep_done,
  output logic                           o_overrun
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  state_t                                r_state, w_state_next;
  logic [NUM_MOTORS-1:0]                 r_mask;
  logic [IDX_W-1:0]                      r_sel, w_sel_next;
  logic [SW-1:0]                         r_settle;
  logic [NUM_MOTORS-1:0][RESULT_W-1:0]   r_slot;
  logic                                  r_overrun;
  logic                                  w_tick, w_go;
  next_bit_t                             w_first, w_next;

  control_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock    (clock),
    .reset    (reset),
    .i_enable (i_enable),
    .o_tick   (w_tick)
  );

  // The first motor is found from the live mask so the sweep can start the cycle after the tick.
  assign w_first = next_set_bit(8'(i_motor_enable_mask), 4'd0);
  assign w_next  = next_set_bit(8'(r_mask), 4'(r_sel) + 4'd1);
  assign w_go    = w_next.found && i_enable;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state  <= S_IDLE;
      r_sel    <= '0;
      r_mask   <= '0;
      r_settle <= '0;
    end else begin
      r_state  <= w_state_next;
      r_sel    <= w_sel_next;
      r_mask   <= (r_state == S_IDLE && w_tick) ? i_motor_enable_mask : r_mask;
      r_settle <= (r_state == S_WAIT) ? r_settle + SW'(1) : '0;
    end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_slot    <= '0;
      r_overrun <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_MOTORS; i++)
        if (r_state == S_CAPTURE && r_sel == IDX_W'(i)) r_slot[i] <= i_pid_result;
      r_overrun <= (w_tick && r_state != S_IDLE) || (r_overrun && !i_overrun_clear);
    end

  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    case (r_state)
      S_IDLE: if (w_tick) begin
        w_state_next = w_first.found ? S_SELECT : S_DONE;
        w_sel_next   = w_first.found ? IDX_W'(w_first.idx) : r_sel;
      end
      S_SELECT:  w_state_next = S_STROBE;
      S_STROBE:  w_state_next = S_WAIT;
      S_WAIT:    w_state_next = (r_settle == SW'(SETTLE_CYCLES - 1)) ? S_CAPTURE : S_WAIT;
      S_CAPTURE: begin
        w_state_next = w_go ? S_SELECT : S_DONE;
        w_sel_next   = w_go ? IDX_W'(w_next.idx) : r_sel;
      end
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_pid_update   = r_state == S_STROBE;
    o_sweep_busy   = r_state != S_IDLE;
    o_sweep_done   = r_state == S_DONE;
    o_result_valid = '0;
    for (int i = 0; i < NUM_MOTORS; i++)
      if (r_state == S_CAPTURE && r_sel == IDX_W'(i)) o_result_valid[i] = 1'b1;
  end

  assign o_motor_sel   = r_sel;
  assign o_result_flat = r_slot;
  assign o_overrun     = r_overrun;
endmodule

// File: tb/tb_pid_update_scheduler.sv
// tb_pid_update_scheduler: directed sweeps with a scoreboard of expected strobes and captured slot values.
module tb_pid_update_scheduler;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        overrun_clear = 1'b0;
  logic [3:0]  mask = 4'h0;
  logic signed [15:0] pid_res = '0;
  logic [2:0]  motor_sel;
  logic        pid_update, busy, done, ov;
  logic [63:0] flat;
  logic [3:0]  valid;

  logic        en2 = 1'b0;
  logic        clr2 = 1'b0;
  logic signed [15:0] pid2 = '0;
  logic [2:0]  sel2;
  logic        upd2, busy2, done2, ov2;
  logic [63:0] flat2;
  logic [3:0]  valid2;

  int errors = 0;
  int checks = 0;
  int ofs = 0;
  int busy_n, done_n, done_at, valid_n;
  int spos[$];

  typedef struct {
    int          idx;
    logic [15:0] val;
  } res_t;
  int   exp_sel[$];
  res_t exp_res[$];

  always #5 clock = ~clock;

  pid_update_scheduler #(.NUM_MOTORS(4), .IDX_W(3), .TICK_DIV(40), .SETTLE_CYCLES(2)) dut (
    .clock               (clock),
    .reset               (reset),
    .i_enable            (enable),
    .i_motor_enable_mask (mask),
    .i_pid_result        (pid_res),
    .i_overrun_clear     (overrun_clear),
    .o_motor_sel         (motor_sel),
    .o_pid_update        (pid_update),
    .o_result_flat       (flat),
    .o_result_valid      (valid),
    .o_sweep_busy        (busy),
    .o_sweep_done        (done),
    .o_overrun           (ov)
  );

  // Short tick period so a second tick always lands inside a full sweep.
  pid_update_scheduler #(.NUM_MOTORS(4), .IDX_W(3), .TICK_DIV(15), .SETTLE_CYCLES(2)) dut_ov (
    .clock               (clock),
    .reset               (reset),
    .i_enable            (en2),
    .i_motor_enable_mask (4'hf),
    .i_pid_result        (pid2),
    .i_overrun_clear     (clr2),
    .o_motor_sel         (sel2),
    .o_pid_update        (upd2),
    .o_result_flat       (flat2),
    .o_result_valid      (valid2),
    .o_sweep_busy        (busy2),
    .o_sweep_done        (done2),
    .o_overrun           (ov2)
  );

  always @(posedge clock) if (pid_update) pid_res <= 16'(100 + ofs + int'(motor_sel));
  always @(posedge clock) if (upd2) pid2 <= 16'(200 + int'(sel2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) if (pid_update === 1'b1) begin
    if (exp_sel.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL strobe_extra: motor_sel %0d strobed, none expected", motor_sel);
    end else chk("strobe_sel", 64'(motor_sel), 64'(exp_sel.pop_front()));
  end

  always @(negedge clock) if (|valid) begin
    int   idx;
    res_t e;
    idx = 0;
    for (int i = 0; i < 4; i++) if (valid[i]) idx = i;
    chk("valid_onehot", 64'($countones(valid)), 64'd1);
    @(negedge clock);
    if (exp_res.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL capture_extra: slot %0d written, none expected", idx);
    end else begin
      e = exp_res.pop_front();
      chk("valid_idx", 64'(idx), 64'(e.idx));
      chk("slot_val", 64'(flat[16*idx +: 16]), 64'(e.val));
    end
  end

  task automatic push_sweep(input logic [3:0] m, input int o);
    for (int i = 0; i < 4; i++)
      if (m[i]) begin
        exp_sel.push_back(i);
        exp_res.push_back('{i, 16'(100 + o + i)});
      end
  endtask

  task automatic run_sweep(input int drop_at);
    int n;
    n = 0; busy_n = 0; done_n = 0; done_at = 0; valid_n = 0;
    spos.delete();
    while (busy !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("sweep_started", 64'(busy), 64'd1);
    while (busy === 1'b1 && busy_n < 200) begin
      busy_n++;
      if (done) begin
        done_n++;
        done_at = busy_n;
      end
      if (|valid) valid_n++;
      if (pid_update) spos.push_back(busy_n);
      if (busy_n == drop_at) enable = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic chk_sweep(input int k);
    chk("sweep_busy_cycles", 64'(busy_n), 64'(5*k + 1));
    chk("sweep_done_pulses", 64'(done_n), 64'd1);
    chk("sweep_done_time", 64'(done_at), 64'(5*k + 1));
    chk("valid_pulses", 64'(valid_n), 64'(k));
    chk("strobe_count", 64'(spos.size()), 64'(k));
    foreach (spos[j]) chk("strobe_pos", 64'(spos[j]), 64'(2 + 5*j));
  endtask

  task automatic reset_checks();
    chk("rst_motor_sel", 64'(motor_sel), 64'd0);
    chk("rst_pid_update", 64'(pid_update), 64'd0);
    chk("rst_flat", flat, 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_overrun", 64'(ov), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, b, d, u, seen;
    repeat (3) @(negedge clock);
    reset_checks();
    reset = 1'b0;

    mask = 4'hf; ofs = 0;
    push_sweep(4'hf, 0);
    enable = 1'b1;
    run_sweep(0);
    chk_sweep(4);
    chk("t1_flat", flat, {16'd103, 16'd102, 16'd101, 16'd100});

    mask = 4'b1010; ofs = 10;
    push_sweep(4'b1010, 10);
    run_sweep(0);
    chk_sweep(2);
    chk("t2_flat", flat, {16'd113, 16'd102, 16'd111, 16'd100});

    mask = 4'b0000;
    run_sweep(0);
    chk_sweep(0);
    chk("t3_flat", flat, {16'd113, 16'd102, 16'd111, 16'd100});

    // Enable drops during motor 1's first settle cycle.
    mask = 4'hf; ofs = 20;
    push_sweep(4'b0011, 20);
    run_sweep(8);
    chk_sweep(2);
    chk("t5_flat", flat, {16'd113, 16'd102, 16'd121, 16'd120});
    repeat (5) @(negedge clock);
    chk("t5_prescaler", 64'(dut.u_tick.r_count), 64'd0);
    seen = 0;
    repeat (60) begin
      @(negedge clock);
      if (busy) seen = 1;
    end
    chk("t5_no_sweep", 64'(seen), 64'd0);
    chk("t5_prescaler_hold", 64'(dut.u_tick.r_count), 64'd0);

    chk("t4_ov_init", 64'(ov2), 64'd0);
    en2 = 1'b1;
    n = 0;
    while (busy2 !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("t4_started", 64'(busy2), 64'd1);
    b = 0; d = 0; u = 0;
    while (busy2 === 1'b1 && b < 100) begin
      b++;
      if (done2) d++;
      if (upd2) u++;
      @(negedge clock);
    end
    chk("t4_busy_cycles", 64'(b), 64'd21);
    chk("t4_done", 64'(d), 64'd1);
    chk("t4_strobes", 64'(u), 64'd4);
    chk("t4_slots", flat2, {16'd203, 16'd202, 16'd201, 16'd200});
    chk("t4_ov_set", 64'(ov2), 64'd1);
    clr2 = 1'b1;
    @(negedge clock);
    clr2 = 1'b0;
    chk("t4_ov_clear", 64'(ov2), 64'd0);
    clr2 = 1'b1;
    n = 0;
    while (ov2 !== 1'b1 && n < 60) begin
      @(negedge clock);
      n++;
    end
    chk("t4_set_wins", 64'(ov2), 64'd1);
    @(negedge clock);
    chk("t4_ov_held_clear", 64'(ov2), 64'd0);
    clr2 = 1'b0;
    en2 = 1'b0;

    // Reset lands in the STROBE cycle of motor 0.
    ofs = 30;
    exp_sel.push_back(0);
    enable = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("t6_started", 64'(busy), 64'd1);
    @(negedge clock);
    chk("t6_strobe", 64'(pid_update), 64'd1);
    #1 reset = 1'b1;
    #1 reset_checks();
    @(negedge clock);
    reset = 1'b0;
    push_sweep(4'hf, 30);
    run_sweep(0);
    chk_sweep(4);
    chk("t6_flat", flat, {16'd133, 16'd132, 16'd131, 16'd130});

    repeat (3) @(negedge clock);
    chk("sb_strobes_left", 64'(exp_sel.size()), 64'd0);
    chk("sb_results_left", 64'(exp_res.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
